// File: rtl/serial_frame_tx_pkg.sv
// rtl/serial_frame_tx_pkg.sv - shared link definitions for the preamble-framed serial link
package serial_frame_tx_pkg;

    // Line FSM states; the receiving detector uses the same encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam int         DEF_DATA_W   = 8;
    localparam int         DEF_PRE_W    = 4;
    localparam logic [3:0] DEF_PREAMBLE = 4'b1011;
    localparam int         DEF_IDLE_GAP = 1;

    // Bit-counter width: wide enough for the longest of preamble, payload and gap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = 2;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/serial_frame_tx_shift_reg.sv
// rtl/serial_frame_tx_shift_reg.sv - payload shift register, parallel load, MSB-first shift
module tx_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         shift_i,
    output logic         msb_o
);

    logic [W-1:0] shreg_q;

    // Load wins over shift; a shift moves the next payload bit into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[W-2:0], 1'b0};
        end
    end

    assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: preamble, MSB-first payload, idle gap
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               PRE_W    = DEF_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(DEF_PREAMBLE),
    parameter int               IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              serOut,
    output logic              payloadBit,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW       = cnt_width(PRE_W, DATA_W, IDLE_GAP);
    localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          ser_q;
    logic          pb_q;
    logic          fd_q;
    logic          pre_bit_d;
    logic          shift_msb;
    logic          load;
    logic          shift;

    assign load  = (state_q == ST_IDLE) && data_valid;
    assign shift = (state_q == ST_DATA) && clkEn;

    tx_shift_reg #(.W(DATA_W)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (data_in),
        .shift_i (shift),
        .msb_o   (shift_msb)
    );

    // Select the preamble bit for the current count, MSB of the pattern first.
    always_comb begin
        pre_bit_d = 1'b0;
        for (int i = 0; i < PRE_W; i++) begin
            if (cnt_q == CW'(PRE_W - 1 - i)) pre_bit_d = PREAMBLE[i];
        end
    end

    // Frame FSM: handshake on any edge, line bits advance only on clkEn edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            pb_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clkEn) begin
                        ser_q <= 1'b0;
                        pb_q  <= 1'b0;
                    end
                    if (data_valid) begin
                        cnt_q   <= '0;
                        state_q <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (clkEn) begin
                        ser_q <= pre_bit_d;
                        pb_q  <= 1'b0;
                        if (cnt_q == CW'(PRE_W - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (clkEn) begin
                        ser_q <= shift_msb;
                        pb_q  <= 1'b1;
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            fd_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (clkEn) begin
                        ser_q <= 1'b0;
                        pb_q  <= 1'b0;
                        if (cnt_q == CW'(GAP_LAST)) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign data_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign serOut     = ser_q;
    assign payloadBit = pb_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clkEn = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, serOut, payloadBit, busy, frame_done;

    int total = 0;
    int bad   = 0;

    // expected line bit: {serOut, payloadBit, frame_done}
    logic [2:0] exp_q[$];
    logic [7:0] word_q[$];

    int  en_div  = 1;
    int  hs_cnt  = 0;
    int  fd_cnt  = 0;
    int  idle_bits = 0;
    int  det_cnt = 0;
    bit  det_en  = 1'b0;

    serial_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .clkEn      (clkEn),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .serOut     (serOut),
        .payloadBit (payloadBit),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // clkEn pattern: high on one clk edge out of en_div, updated well away from edges
    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #2;
            c = (c + 1) % en_div;
            clkEn = (c == 0);
        end
    end

    // Monitor: every clkEn edge taken while busy is one frame bit to pop and compare.
    initial begin
        logic       en_p, busy_p, hs_p;
        logic [2:0] e;
        logic [3:0] hist = 4'h0;
        logic [7:0] word = 8'h00;
        int         n = 0;
        bit         collecting = 1'b0;
        forever begin
            @(negedge clk);
            en_p   = clkEn;
            busy_p = busy;
            hs_p   = data_valid && data_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                if (hs_p) hs_cnt++;
                if (frame_done) fd_cnt++;
                if (en_p && !busy_p) idle_bits++;
                if (en_p && busy_p) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", {29'd0, serOut, payloadBit, frame_done}, 32'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("line_bit", {29'd0, serOut, payloadBit, frame_done}, {29'd0, e});
                    end
                end
                if (det_en && en_p) begin
                    if (collecting) begin
                        word = {word[6:0], serOut};
                        n++;
                        if (n == 8) begin
                            collecting = 1'b0;
                            hist = 4'h0;
                            det_cnt++;
                            if (word_q.size() == 0)
                                check("spurious_frame", {24'd0, word}, 32'hDEAD);
                            else
                                check("rx_word", {24'd0, word}, {24'd0, word_q.pop_front()});
                        end
                    end else begin
                        hist = {hist[2:0], serOut};
                        if (hist == 4'b1011) begin
                            collecting = 1'b1;
                            n = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] w);
        logic [3:0] pre;
        pre = 4'b1011;
        for (int i = 3; i >= 0; i--) exp_q.push_back({pre[i], 1'b0, 1'b0});
        for (int i = 7; i >= 0; i--) exp_q.push_back({w[i], 1'b1, (i == 0)});
        exp_q.push_back(3'b000);
    endtask

    // Offer a word; expectations are queued on the edge that accepts it.
    task automatic send(input logic [7:0] w, input bit want_en0, input bit keep);
        int n;
        n = 0;
        data_in = w;
        forever begin
            @(negedge clk);
            if (data_ready && (!want_en0 || !clkEn)) break;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL send_timeout: word %0h never accepted", w);
                data_valid = 1'b0;
                return;
            end
        end
        data_valid = 1'b1;
        @(posedge clk);
        push_frame(w);
        if (det_en) word_q.push_back(w);
        #3;
        if (!keep) data_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Asynchronous reset hit between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        word_q.delete();
        #1;
        check({tag, "_serOut"},     {31'd0, serOut},     32'd0);
        check({tag, "_data_ready"}, {31'd0, data_ready}, 32'd1);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_payloadBit"}, {31'd0, payloadBit}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, fd0, hs0, i0;
        logic [7:0] w;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_serOut", {31'd0, serOut}, 32'd0);
        check("rst_ready",  {31'd0, data_ready}, 32'd1);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_fd",     {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // test 1: reset asserted mid-frame
        en_div = 1;
        send(8'h55, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        do_reset("t1");
        repeat (2) @(negedge clk);

        // test 2: single frame, clkEn always high
        fd0 = fd_cnt;
        send(8'hA5, 1'b0, 1'b0);
        n = 0;
        while (!data_ready && n < 100) begin
            @(negedge clk);
            if (!data_ready) n++;
        end
        begin
            int k;
            k = 0;
            @(negedge clk);
        end
        drain();
        check("t2_fd_pulses", fd_cnt - fd0, 32'd1);

        // test 2b: data_ready low time re-measured from the handshake
        send(8'hA5, 1'b0, 1'b0);
        n = 0;
        forever begin
            @(negedge clk);
            if (data_ready || n > 100) break;
            n++;
        end
        check("t2_ready_low", n, 32'd13);
        drain();

        // test 3: clkEn every 3rd clk, handshake while clkEn low
        en_div = 3;
        repeat (4) @(negedge clk);
        send(8'h3C, 1'b1, 1'b0);
        drain();

        // test 4: back-to-back with data_valid held
        hs0 = hs_cnt;
        send(8'hB0, 1'b0, 1'b1);
        i0 = idle_bits;
        send(8'hFF, 1'b0, 1'b0);
        check("t4_idle_bits", idle_bits - i0, 32'd0);
        drain();
        check("t4_handshakes", hs_cnt - hs0, 32'd2);

        // test 5: reset during payload bit 3, then a clean frame
        en_div = 1;
        repeat (3) @(negedge clk);
        send(8'h96, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t5_in_payload", {31'd0, payloadBit}, 32'd1);
        do_reset("t5");
        send(8'h81, 1'b0, 1'b0);
        drain();

        // test 6: loopback into a preamble detector
        en_div = 2;
        det_en = 1'b1;
        det_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            case (k)
                0:       w = 8'h0B;
                1:       w = 8'hB0;
                2:       w = 8'h00;
                default: w = 8'($urandom_range(0, 255));
            endcase
            send(w, 1'b0, 1'b0);
        end
        drain();
        repeat (10) @(negedge clk);
        check("t6_rx_count", det_cnt, 32'd200);
        check("t6_words_left", word_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
